// File: rtl/avg_pool2x2_ctrl.sv
// avg_pool2x2_ctrl: streaming 2x2 / stride-2 average pooling for one channel.
// Even rows are parked in a line buffer. Odd rows pair with them to form
// each window. Each window is reduced to floor(sum/4) and handed downstream
// through a single output register with valid/ready handshaking.
module avg_pool2x2_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int SW = DATA_WIDTH + 2;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  localparam logic [0:0] EVEN_ROW = 1'b0;
  localparam logic [0:0] ODD_ROW  = 1'b1;

  // Four-operand average. Two guard bits make the sum exact. The arithmetic
  // shift then floors toward -inf, and the result always fits back in
  // DATA_WIDTH.
  function automatic logic signed [DATA_WIDTH-1:0] pool_avg(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b,
    input logic signed [DATA_WIDTH-1:0] c,
    input logic signed [DATA_WIDTH-1:0] d
  );
    logic signed [SW-1:0] ea, eb, ec, ed, sum, shr;
    ea  = {{2{a[DATA_WIDTH-1]}}, a};
    eb  = {{2{b[DATA_WIDTH-1]}}, b};
    ec  = {{2{c[DATA_WIDTH-1]}}, c};
    ed  = {{2{d[DATA_WIDTH-1]}}, d};
    sum = ea + eb + ec + ed;
    shr = sum >>> 2;
    return shr[DATA_WIDTH-1:0];
  endfunction

  logic [CW-1:0]                col_q, col_d;
  logic [RW-1:0]                row_q, row_d;
  logic [0:0]                   state_q, state_d;
  logic signed [DATA_WIDTH-1:0] hold_q;
  logic signed [DATA_WIDTH-1:0] prev_q;
  logic signed [DATA_WIDTH-1:0] out_data_q;
  logic                         out_valid_q;
  logic                         last_q;

  logic signed [DATA_WIDTH-1:0] line_buf [IMG_W];
  logic signed [DATA_WIDTH-1:0] in_pix;
  logic signed [DATA_WIDTH-1:0] lb_rd;
  logic                         in_xfer;
  logic                         out_xfer;
  logic                         col_last;
  logic                         row_last;
  logic                         odd_col;
  logic                         load_even;
  logic                         load_win;

  assign in_pix    = $signed(in_data);
  assign lb_rd     = line_buf[col_q];
  assign in_ready  = !out_valid_q || out_ready;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid_q && out_ready;
  assign col_last  = (col_q == COL_LAST);
  assign row_last  = (row_q == ROW_LAST);
  assign odd_col   = col_q[0];
  assign load_even = in_xfer && (state_q == ODD_ROW) && !odd_col;
  assign load_win  = in_xfer && (state_q == ODD_ROW) && odd_col;

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign frame_done = out_xfer && last_q;

  // Raster position and row-parity FSM advance on every accepted pixel
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    state_d = state_q;
    if (in_xfer) begin
      if (col_last) begin
        col_d   = '0;
        row_d   = row_last ? '0 : row_q + RW'(1);
        state_d = (state_q == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Control, window holding registers and the single output slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      state_q     <= EVEN_ROW;
      hold_q      <= '0;
      prev_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      state_q <= state_d;
      if (load_even) begin
        hold_q <= in_pix;
        prev_q <= lb_rd;
      end
      if (load_win) begin
        out_data_q  <= pool_avg(prev_q, lb_rd, hold_q, in_pix);
        out_valid_q <= 1'b1;
        last_q      <= row_last && col_last;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Even-row pixels are stored for pairing with the following odd row
  always_ff @(posedge clk) begin
    if (in_xfer && (state_q == EVEN_ROW)) begin
      line_buf[col_q] <= in_pix;
    end
  end

endmodule

// File: tb/tb_avg_pool2x2_ctrl.sv
// Directed bench for avg_pool2x2_ctrl: a 4x2 instance for small frames and a
// 28x28 instance for the streamed ramp frame with random handshakes.
module tb_avg_pool2x2_ctrl;

  logic clk;
  logic rst_n;

  logic [15:0] s_in_data, s_out_data;
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_frame_done;
  logic [15:0] b_in_data, b_out_data;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_frame_done;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] s_q[$];
  logic        s_fdq[$];
  int          s_fd_cnt = 0;
  logic [15:0] b_q[$];
  logic        b_fdq[$];
  int          b_fd_cnt = 0;
  logic        s_timeout = 1'b0;
  logic        b_timeout = 1'b0;
  logic        b_done;

  logic [15:0] F1 [8] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};

  avg_pool2x2_ctrl #(.DATA_WIDTH(16), .IMG_W(4), .IMG_H(2)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .frame_done(s_frame_done)
  );

  avg_pool2x2_ctrl #(.DATA_WIDTH(16), .IMG_W(28), .IMG_H(28)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .frame_done(b_frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output transfers are captured mid-cycle, when inputs are stable
  always @(negedge clk) begin
    if (s_out_valid && s_out_ready) begin
      s_q.push_back(s_out_data);
      s_fdq.push_back(s_frame_done);
    end
    if (s_frame_done) s_fd_cnt++;
    if (b_out_valid && b_out_ready) begin
      b_q.push_back(b_out_data);
      b_fdq.push_back(b_frame_done);
    end
    if (b_frame_done) b_fd_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic s_push(input logic [15:0] p);
    int guard;
    guard = 0;
    s_in_data  = p;
    s_in_valid = 1'b1;
    #1;
    while (!s_in_ready && guard < 200) begin
      @(posedge clk);
      #2;
      guard++;
    end
    if (guard >= 200) s_timeout = 1'b1;
    tick();
    s_in_valid = 1'b0;
  endtask

  task automatic b_push(input logic [15:0] p);
    int guard;
    guard = 0;
    b_in_data  = p;
    b_in_valid = 1'b1;
    #1;
    while (!b_in_ready && guard < 500) begin
      @(posedge clk);
      #2;
      guard++;
    end
    if (guard >= 500) b_timeout = 1'b1;
    tick();
    b_in_valid = 1'b0;
  endtask

  task automatic s_frame(input logic [15:0] px [8]);
    for (int i = 0; i < 8; i++) s_push(px[i]);
  endtask

  task automatic s_drain(input int n);
    int guard;
    guard = 0;
    while (s_q.size() < n && guard < 50) begin
      tick();
      guard++;
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    #3;
    n_assert++;
    if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", s_out_valid); end
    n_assert++;
    if (s_out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data got %h want 0000", s_out_data); end
    n_assert++;
    if (s_frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %b want 0", s_frame_done); end
    n_assert++;
    if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", s_in_ready); end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic vrec [10];
    int   fd0;
    s_q.delete(); s_fdq.delete();
    fd0 = s_fd_cnt;
    s_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        s_in_valid = 1'b1;
        s_in_data  = F1[i];
      end else begin
        s_in_valid = 1'b0;
      end
      #1;
      vrec[i] = s_out_valid;
      tick();
    end
    s_in_valid = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 10; i++) begin
      n_assert++;
      if (vrec[i] !== ((i == 6) || (i == 8))) begin
        n_fail++;
        $display("FAIL basic_valid_timing cycle %0d got %b want %b", i, vrec[i], (i == 6) || (i == 8));
      end
    end
    n_assert++;
    if (s_q.size() !== 2) begin
      n_fail++; $display("FAIL basic_count got %0d want 2", s_q.size());
    end else begin
      n_assert++;
      if (s_q[0] !== 16'd3) begin n_fail++; $display("FAIL basic_out0 got %0d want 3", s_q[0]); end
      n_assert++;
      if (s_q[1] !== 16'd5) begin n_fail++; $display("FAIL basic_out1 got %0d want 5", s_q[1]); end
      n_assert++;
      if (s_fdq[0] !== 1'b0 || s_fdq[1] !== 1'b1) begin
        n_fail++; $display("FAIL basic_frame_done got %b%b want 01", s_fdq[0], s_fdq[1]);
      end
    end
    n_assert++;
    if (s_fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL basic_fd_pulses got %0d want 1", s_fd_cnt - fd0); end
  endtask

  task automatic test_negative();
    logic [15:0] px [8];
    px = '{16'hFFFF, 16'hFFFE, 16'hFFFF, 16'h0000,
           16'hFFFD, 16'hFFFC, 16'h0000, 16'h0000};
    s_q.delete(); s_fdq.delete();
    s_out_ready = 1'b1;
    s_frame(px);
    s_drain(2);
    n_assert++;
    if (s_q.size() !== 2) begin
      n_fail++; $display("FAIL neg_count got %0d want 2", s_q.size());
    end else begin
      n_assert++;
      if (s_q[0] !== 16'hFFFD) begin n_fail++; $display("FAIL neg_floor got %h want fffd", s_q[0]); end
      n_assert++;
      if (s_q[1] !== 16'hFFFF) begin n_fail++; $display("FAIL neg_minus1 got %h want ffff", s_q[1]); end
    end
  endtask

  task automatic test_extremes();
    logic [15:0] pa [8];
    logic [15:0] pb [8];
    pa = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000,
           16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000};
    pb = '{16'h7FFF, 16'h7FFF, 16'd5, 16'd5,
           16'h8000, 16'h8000, 16'd5, 16'd5};
    s_q.delete(); s_fdq.delete();
    s_out_ready = 1'b1;
    s_frame(pa);
    s_frame(pb);
    s_drain(4);
    n_assert++;
    if (s_q.size() !== 4) begin
      n_fail++; $display("FAIL ext_count got %0d want 4", s_q.size());
    end else begin
      n_assert++;
      if (s_q[0] !== 16'h7FFF) begin n_fail++; $display("FAIL ext_max got %h want 7fff", s_q[0]); end
      n_assert++;
      if (s_q[1] !== 16'h8000) begin n_fail++; $display("FAIL ext_min got %h want 8000", s_q[1]); end
      n_assert++;
      if (s_q[2] !== 16'hFFFF) begin n_fail++; $display("FAIL ext_mixed got %h want ffff", s_q[2]); end
      n_assert++;
      if (s_q[3] !== 16'd5) begin n_fail++; $display("FAIL ext_fives got %h want 0005", s_q[3]); end
    end
  endtask

  task automatic test_backpressure();
    int fd0;
    s_q.delete(); s_fdq.delete();
    fd0 = s_fd_cnt;
    s_out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_in_valid = 1'b1;
      s_in_data  = F1[i];
      tick();
    end
    s_in_data = F1[6];
    #1;
    n_assert++;
    if (s_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", s_in_ready); end
    n_assert++;
    if (s_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid got %b want 1", s_out_valid); end
    n_assert++;
    if (s_out_data !== 16'd3) begin n_fail++; $display("FAIL bp_out_data got %0d want 3", s_out_data); end
    repeat (5) tick();
    #1;
    n_assert++;
    if (s_out_data !== 16'd3 || s_out_valid !== 1'b1 || s_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_hold got data %0d valid %b ready %b want 3 1 0", s_out_data, s_out_valid, s_in_ready);
    end
    n_assert++;
    if (s_q.size() !== 0) begin n_fail++; $display("FAIL bp_no_transfer got %0d want 0", s_q.size()); end
    s_out_ready = 1'b1;
    s_push(F1[6]);
    s_push(F1[7]);
    s_drain(2);
    n_assert++;
    if (s_q.size() !== 2) begin
      n_fail++; $display("FAIL bp_count got %0d want 2", s_q.size());
    end else begin
      n_assert++;
      if (s_q[0] !== 16'd3 || s_q[1] !== 16'd5) begin
        n_fail++; $display("FAIL bp_values got %0d,%0d want 3,5", s_q[0], s_q[1]);
      end
      n_assert++;
      if (s_fdq[1] !== 1'b1) begin n_fail++; $display("FAIL bp_frame_done got %b want 1", s_fdq[1]); end
    end
    n_assert++;
    if (s_fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL bp_fd_pulses got %0d want 1", s_fd_cnt - fd0); end
  endtask

  task automatic test_ramp_random();
    int cyc;
    b_q.delete(); b_fdq.delete();
    b_fd_cnt = 0;
    b_done   = 1'b0;
    fork
      begin
        for (int r = 0; r < 28; r++) begin
          for (int c = 0; c < 28; c++) begin
            while ($urandom_range(1) == 0) tick();
            b_push(16'(28 * r + c));
          end
        end
        b_done = 1'b1;
      end
      begin
        cyc = 0;
        while (!(b_done && b_q.size() >= 196) && cyc < 30000) begin
          tick();
          b_out_ready = 1'($urandom_range(1));
          cyc++;
        end
        b_out_ready = 1'b1;
      end
    join
    repeat (5) tick();
    n_assert++;
    if (b_timeout !== 1'b0) begin n_fail++; $display("FAIL ramp_timeout got %b want 0", b_timeout); end
    n_assert++;
    if (b_q.size() !== 196) begin
      n_fail++; $display("FAIL ramp_count got %0d want 196", b_q.size());
    end else begin
      for (int k = 0; k < 196; k++) begin
        n_assert++;
        if (b_q[k] !== 16'(56 * (k / 14) + 2 * (k % 14) + 14)) begin
          n_fail++;
          $display("FAIL ramp_value idx %0d got %0d want %0d", k, b_q[k], 56 * (k / 14) + 2 * (k % 14) + 14);
        end
      end
      n_assert++;
      if (b_fdq[195] !== 1'b1) begin n_fail++; $display("FAIL ramp_fd_last got %b want 1", b_fdq[195]); end
    end
    n_assert++;
    if (b_fd_cnt !== 1) begin n_fail++; $display("FAIL ramp_fd_pulses got %0d want 1", b_fd_cnt); end
  endtask

  task automatic test_reset_midframe();
    s_q.delete(); s_fdq.delete();
    s_out_ready = 1'b0;
    for (int i = 0; i < 6; i++) s_push(F1[i]);
    #1;
    n_assert++;
    if (s_out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_valid got %b want 1", s_out_valid); end
    rst_n = 1'b0;
    #1;
    n_assert++;
    if (s_out_valid !== 1'b0 || s_out_data !== 16'h0000 || s_frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_clear got valid %b data %h fd %b want 0 0000 0", s_out_valid, s_out_data, s_frame_done);
    end
    tick();
    rst_n = 1'b1;
    s_out_ready = 1'b1;
    tick();
    s_frame(F1);
    s_drain(2);
    n_assert++;
    if (s_q.size() !== 2) begin
      n_fail++; $display("FAIL rst_mid_count got %0d want 2", s_q.size());
    end else begin
      n_assert++;
      if (s_q[0] !== 16'd3 || s_q[1] !== 16'd5) begin
        n_fail++; $display("FAIL rst_mid_values got %0d,%0d want 3,5", s_q[0], s_q[1]);
      end
      n_assert++;
      if (s_fdq[0] !== 1'b0 || s_fdq[1] !== 1'b1) begin
        n_fail++; $display("FAIL rst_mid_fd got %b%b want 01", s_fdq[0], s_fdq[1]);
      end
    end
    n_assert++;
    if (s_timeout !== 1'b0) begin n_fail++; $display("FAIL small_timeout got %b want 0", s_timeout); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_extremes();
    test_backpressure();
    test_ramp_random();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
